// File: rtl/parity_stream_gen.sv
// ---------------------------------------------------------------------------
// parity_stream_gen
//
// Accumulates parity over a frame of WIDTH-bit words received on a
// valid/ready stream and presents the frame's even/odd parity bits, the word
// count and an overflow flag on a held valid/ready result handshake.
// A frame ends on in_last or, at the latest, on its MAX_WORDS-th word.
//
// Optional build macro: PARITY_CHECK_EN
//   Adds exp_parity (sampled with the terminating beat) and parity_err
//   (result parity differs from the expected bit while the result is shown).
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid     input word present
//   in_ready     block can accept a word (low in DONE and during reset)
//   in_data      input word, WIDTH bits
//   in_last      final word of frame, qualified by in_valid
//   out_valid    frame result available
//   out_ready    consumer accepts the result
//   parity_even  XOR of all frame bits
//   parity_odd   inverse of parity_even
//   word_count   words in frame, $clog2(MAX_WORDS+1) bits
//   overflow     frame was ended by MAX_WORDS rather than by in_last
//   exp_parity   (PARITY_CHECK_EN) expected even parity for the frame
//   parity_err   (PARITY_CHECK_EN) result parity mismatch
// ---------------------------------------------------------------------------
module parity_stream_gen #(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16,
    localparam int CW       = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             parity_even,
    output logic             parity_odd,
    output logic [CW-1:0]    word_count,
    output logic             overflow
`ifdef PARITY_CHECK_EN
    ,
    input  logic             exp_parity,
    output logic             parity_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ACCUM = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

    // Reduction parity of one input word.
    function automatic logic word_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction

    state_t          state_q, state_d;
    logic            acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;

    logic            accept_s;
    logic            acc_base_s;
    logic [CW-1:0]   cnt_base_s;
    logic [CW-1:0]   cnt_inc_s;
    logic            hit_max_s;
    logic            term_s;

    // in_ready is forced low while rst is held so no beat is offered during reset.
    assign in_ready  = !rst && (state_q != S_DONE);
    assign accept_s  = in_valid && in_ready;

    // A fresh frame starts from zero regardless of leftover register contents.
    assign acc_base_s = (state_q == S_IDLE) ? 1'b0 : acc_q;
    assign cnt_base_s = (state_q == S_IDLE) ? {CW{1'b0}} : cnt_q;
    assign cnt_inc_s  = cnt_base_s + CW'(1);
    assign hit_max_s  = (cnt_inc_s == MAX_CNT);
    assign term_s     = accept_s && (in_last || hit_max_s);

    // Next-state and datapath update for the frame FSM.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (accept_s) begin
                    acc_d = acc_base_s ^ word_parity(in_data);
                    cnt_d = cnt_inc_s;
                    if (term_s) begin
                        state_d = S_DONE;
                        ovf_d   = hit_max_s && !in_last;
                    end else begin
                        state_d = S_ACCUM;
                        ovf_d   = 1'b0;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    acc_d   = 1'b0;
                    cnt_d   = {CW{1'b0}};
                    ovf_d   = 1'b0;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                acc_d   = 1'b0;
                cnt_d   = {CW{1'b0}};
                ovf_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Result fields are register values gated by the DONE decode, so they
    // read zero whenever no result is being offered.
    assign out_valid   = (state_q == S_DONE);
    assign parity_even = out_valid && acc_q;
    assign parity_odd  = out_valid && !acc_q;
    assign word_count  = out_valid ? cnt_q : {CW{1'b0}};
    assign overflow    = out_valid && ovf_q;

`ifdef PARITY_CHECK_EN
    logic exp_q;

    // Capture the expected parity with the terminating beat; clear on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q <= 1'b0;
        end else if (term_s) begin
            exp_q <= exp_parity;
        end else if (out_valid && out_ready) begin
            exp_q <= 1'b0;
        end else begin
            exp_q <= exp_q;
        end
    end

    assign parity_err = out_valid && (exp_q != acc_q);
`endif

endmodule

// File: doc/parity_stream_gen.md
Name: parity_stream_gen

Overview:
- Parametrised, sequential successor to the 3-bit combinational parity generator.
- Accepts a frame of WIDTH-bit words over a valid/ready stream and accumulates parity across the whole frame.
- Presents the frame's even and odd parity bits, with a word count, on a held output handshake.
- Sits between a packet source and a link framer that appends the parity bit.

Parameters:
WIDTH, 8, data word width in bits (>=1)
MAX_WORDS, 16, maximum words per frame; frame force-terminates at this count (>=1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input word present
in_ready  output  1  block can accept a word
in_data  input  WIDTH  input word
in_last  input  1  marks final word of frame, qualified by in_valid
out_valid  output  1  frame result available
out_ready  input  1  consumer accepts result
parity_even  output  1  even parity bit for frame (XOR of all frame bits)
parity_odd  output  1  odd parity bit for frame (inverse of parity_even)
word_count  output  CW  words in frame, CW = $clog2(MAX_WORDS+1)
overflow  output  1  frame ended by MAX_WORDS, not by in_last

Behaviour:
- Reset:
  - Asynchronous assert, synchronous release.
  - State=IDLE; accumulator, counter, overflow flag cleared.
  - out_valid, parity_even, parity_odd, word_count and overflow are 0.
  - in_ready = 0 while rst is high.
- Accept: a beat transfers when in_valid && in_ready. in_data and in_last are ignored otherwise.
- in_ready = 1 in IDLE and ACCUM; 0 in DONE.
- IDLE:
  - On an accepted beat: acc <= ^in_data, cnt <= 1.
  - Go to DONE if in_last or MAX_WORDS==1; otherwise go to ACCUM.
- ACCUM:
  - On an accepted beat: acc <= acc ^ (^in_data), cnt <= cnt+1.
  - Go to DONE if in_last or cnt+1 == MAX_WORDS.
  - Bubbles (in_valid=0) hold all state.
- Frame termination on the terminating beat:
  - overflow flag <= (cnt+1 == MAX_WORDS) && !in_last.
  - in_last on exactly the MAX_WORDS-th beat gives overflow=0.
- DONE:
  - out_valid=1; parity_even=acc; parity_odd=~acc; word_count=cnt; overflow=flag.
  - All outputs held stable until out_ready.
  - On out_valid && out_ready: go to IDLE; acc, cnt and flag cleared.
- Output gating: when out_valid=0, parity_even, parity_odd, word_count and overflow are all driven 0.
- Latency and throughput:
  - out_valid rises the cycle after the terminating beat is accepted.
  - Result handshake to next in_ready=1 is one cycle.
  - Minimum frame-to-frame gap is one cycle (the DONE cycle).
- out_ready high outside DONE has no effect.
- Reset mid-frame or in DONE discards the partial or unconsumed result; there is no output glitch beyond the reset values.
- Outputs are registers or state decodes only; there are no combinational paths from in_* to out_*.

Optional Feature:
- Macro PARITY_CHECK_EN.
- Defined:
  - Adds input exp_parity (1 bit), sampled with the terminating beat.
  - Adds output parity_err (1 bit) = out_valid && (exp_parity_sampled != acc).
  - parity_err is held through DONE and is 0 otherwise, including during reset.
- Undefined: neither port exists and there is no checker logic. Generator behaviour is identical in both builds.

Test Plan:
All scenarios use WIDTH=8, MAX_WORDS=4.
- Single word 8'hA5 with in_last -> next cycle out_valid=1, parity_even=0, parity_odd=1, word_count=1, overflow=0.
- Words 8'h01, 8'h03, 8'h03 with bubbles between them, last on the third -> parity_even=1, parity_odd=0, word_count=3, overflow=0.
- Backpressure: after frame 8'h07+last, hold out_ready=0 for 5 cycles while in_valid=1 -> outputs stable and in_ready=0 throughout; raise out_ready -> next cycle out_valid=0 and in_ready=1.
- Overflow: 8'hFF, 8'h00, 8'h01, 8'h00 with no in_last -> parity_even=1, word_count=4, overflow=1. The same frame with in_last on word 4 -> overflow=0.
- Reset mid-frame after 2 accepted words, then frame 8'h80+last -> during reset all outputs are 0; result is parity_even=1, word_count=1, overflow=0.
- With PARITY_CHECK_EN: frame 8'hA5+last with exp_parity=1 -> parity_err=1; with exp_parity=0 -> parity_err=0; parity_err=0 after the result handshake.
